// File: rtl/mult_pkg.sv
// Shared definitions for the bit-serial multiplier: FSM state encoding,
// a constant-evaluable clog2, and the Baugh-Wooley correction columns.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Signed mode adds a constant 1 at these two product columns.
    function automatic int bw_col_lo(input int w);
        return w;
    endfunction

    function automatic int bw_col_hi(input int w);
        return 2 * w - 1;
    endfunction

endpackage

// File: rtl/serial_column_adder.sv
// Column-wise product generator: for column k it adds every partial product
// with i+j==k to the running carry, emits the LSB, and keeps the rest as
// carry for column k+1. Signed mode applies Baugh-Wooley inversion/constants.
module serial_column_adder
    import mult_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W) + 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [W-1:0]              a_i,
    input  logic [W-1:0]              b_i,
    input  logic [clog2(2*W)-1:0]     k_i,
    input  logic                      sgn_i,
    input  logic                      en_i,
    input  logic                      clr_i,
    output logic                      bit_o
);

    // The carry never exceeds W, so the column sum stays below 2W+2 and
    // fits in CW bits for every legal W.
    logic [CW-1:0] carry_q;
    logic [CW-1:0] carry_d;
    logic [CW-1:0] sum;
    logic          pp;

    // Population count of column k's partial products plus carry and correction.
    always_comb begin
        sum = carry_q;
        pp  = 1'b0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                if (i + j == int'(k_i)) begin
                    pp = a_i[i] & b_i[j];
                    if (sgn_i && ((i == W - 1) != (j == W - 1))) begin
                        pp = ~pp;
                    end
                    sum = sum + CW'(pp);
                end
            end
        end
        if (sgn_i && (int'(k_i) == bw_col_lo(W) || int'(k_i) == bw_col_hi(W))) begin
            sum = sum + CW'(1);
        end
        carry_d = sum >> 1;
    end

    assign bit_o = sum[0];

    // Carry register: cleared at operation start, advanced once per emitted bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            carry_q <= '0;
        end else if (clr_i) begin
            carry_q <= '0;
        end else if (en_i) begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/bit_serial_mult_n.sv
// Bit-serial W x W multiplier. Operands shift in LSB-first over W cycles
// (IDLE start edge plus W-1 LOAD edges); the 2W-bit product then leaves
// LSB-first over 2W OUT cycles with O_VLD high and DONE on the last bit.
module bit_serial_mult_n
    import mult_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W) + 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic START,
    input  logic SGN,
    input  logic A,
    input  logic B,
    output logic BUSY,
    output logic O,
    output logic O_VLD,
    output logic DONE
);

    localparam int KW = clog2(2 * W);

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          sgn_q, sgn_d;
    logic          o_q, o_d;
    logic          vld_q, vld_d;
    logic          done_q, done_d;
    logic          start_now;
    logic          col_bit;
    logic          col_en;
    logic          col_clr;

    serial_column_adder #(
        .W  (W),
        .CW (CW)
    ) u_col (
        .CLK   (CLK),
        .RST   (RST),
        .a_i   (a_q),
        .b_i   (b_q),
        .k_i   (k_q),
        .sgn_i (sgn_q),
        .en_i  (col_en),
        .clr_i (col_clr),
        .bit_o (col_bit)
    );

    // Next-state logic: sequencing, operand shifting and output bit selection.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        o_d       = 1'b0;
        vld_d     = 1'b0;
        done_d    = 1'b0;
        start_now = 1'b0;
        col_en    = 1'b0;
        col_clr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start_now = START;
            end
            ST_LOAD: begin
                a_d = {A, a_q[W-1:1]};
                b_d = {B, b_q[W-1:1]};
                if (k_q == KW'(W - 1)) begin
                    state_d = ST_OUT;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_OUT: begin
                if (done_q) begin
                    // Last bit already shown: return to IDLE, or restart at once.
                    state_d   = ST_IDLE;
                    k_d       = '0;
                    start_now = START;
                end else begin
                    o_d    = col_bit;
                    vld_d  = 1'b1;
                    done_d = (k_q == KW'(2 * W - 1));
                    k_d    = k_q + KW'(1);
                    col_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_now) begin
            a_d     = {A, a_q[W-1:1]};
            b_d     = {B, b_q[W-1:1]};
            sgn_d   = SGN;
            k_d     = KW'(1);
            state_d = ST_LOAD;
            col_clr = 1'b1;
        end
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            o_q     <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            o_q     <= o_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign BUSY  = (state_q != ST_IDLE);
    assign O     = o_q;
    assign O_VLD = vld_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_bit_serial_mult_n.sv
// Directed and randomised bench for bit_serial_mult_n at W = 4, 8 and 16.
module tb_bit_serial_mult_n;

    logic CLK;
    logic RST;
    logic START;
    logic SGN;
    logic A;
    logic B;
    int   cur_w;

    logic st4, st8, st16;
    logic busy4, o4, vld4, done4;
    logic busy8, o8, vld8, done8;
    logic busy16, o16, vld16, done16;
    logic busy_m, o_m, vld_m, done_m;

    int n_tests;
    int n_fail;

    assign st4  = START && (cur_w == 4);
    assign st8  = START && (cur_w == 8);
    assign st16 = START && (cur_w == 16);

    bit_serial_mult_n #(.W(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .START(st4), .SGN(SGN), .A(A), .B(B),
        .BUSY(busy4), .O(o4), .O_VLD(vld4), .DONE(done4)
    );

    bit_serial_mult_n #(.W(8)) u_dut8 (
        .CLK(CLK), .RST(RST), .START(st8), .SGN(SGN), .A(A), .B(B),
        .BUSY(busy8), .O(o8), .O_VLD(vld8), .DONE(done8)
    );

    bit_serial_mult_n #(.W(16)) u_dut16 (
        .CLK(CLK), .RST(RST), .START(st16), .SGN(SGN), .A(A), .B(B),
        .BUSY(busy16), .O(o16), .O_VLD(vld16), .DONE(done16)
    );

    // Route the outputs of the instance currently being exercised.
    always_comb begin
        case (cur_w)
            4:       {busy_m, o_m, vld_m, done_m} = {busy4, o4, vld4, done4};
            16:      {busy_m, o_m, vld_m, done_m} = {busy16, o16, vld16, done16};
            default: {busy_m, o_m, vld_m, done_m} = {busy8, o8, vld8, done8};
        endcase
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input int w, input logic sgn,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] m;
        m  = (64'd1 << (2 * w)) - 64'd1;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        return 64'(sa * sb) & m;
    endfunction

    // Drive one operation and collect its serial result. Inputs change on the
    // falling edge; outputs are sampled on the falling edge after each rising edge.
    task automatic run_op(input string tag, input int w, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                          input bit hold, input bit started, input bit chain,
                          input logic sgn2, input logic [31:0] a2, input logic [31:0] b2,
                          input int abort_at);
        logic [63:0] p;
        int lat, nvld, done_idx, done_cnt, stray;
        bit busy_first, ended, chained;
        p = '0; lat = -1; nvld = 0; done_idx = -1; done_cnt = 0; stray = 0;
        busy_first = 0; ended = 0; chained = 0;
        cur_w = w;
        if (!started) begin
            @(negedge CLK);
            START = 1'b1; SGN = sgn; A = a[0]; B = b[0];
        end
        for (int c = 0; c <= 3 * w + 4; c++) begin
            @(negedge CLK);
            if (c == 0) busy_first = busy_m;
            if (vld_m) begin
                if (nvld == 0) lat = c;
                if (nvld < 64) p = p | (64'(o_m) << nvld);
                nvld++;
                if (done_m) done_idx = nvld - 1;
            end else begin
                if (o_m) stray++;
                if (nvld > 0) ended = 1;
            end
            if (done_m) done_cnt++;
            if (c == abort_at) return;
            if (ended) break;
            if (chain && c == 3 * w - 1) begin
                START = 1'b1; SGN = sgn2; A = a2[0]; B = b2[0];
                chained = 1;
                break;
            end
            START = hold && (c + 1 < 3 * w);
            SGN   = ~sgn;
            if (c + 1 < w) begin
                A = 1'(a >> (c + 1));
                B = 1'(b >> (c + 1));
            end else begin
                A = 1'($urandom);
                B = 1'($urandom);
            end
        end
        check({tag, " product"}, p, exp);
        check({tag, " latency"}, 64'(lat), 64'(w));
        check({tag, " vld count"}, 64'(nvld), 64'(2 * w));
        check({tag, " done pos"}, 64'(done_idx), 64'(2 * w - 1));
        check({tag, " done count"}, 64'(done_cnt), 64'd1);
        check({tag, " O w/o vld"}, 64'(stray), 64'd0);
        check({tag, " busy at start"}, 64'(busy_first), 64'd1);
        if (!chained) check({tag, " busy after"}, 64'(busy_m), 64'd0);
    endtask

    initial begin
        int quiet;
        int rw;
        logic rs;
        logic [31:0] ra, rb, mask;

        n_tests = 0; n_fail = 0;
        RST = 1'b0; START = 1'b0; SGN = 1'b0; A = 1'b0; B = 1'b0; cur_w = 8;
        repeat (2) @(negedge CLK);
        check("reset outputs w8", 64'({busy8, o8, vld8, done8}), 64'd0);
        check("reset outputs w4", 64'({busy4, o4, vld4, done4}), 64'd0);
        RST = 1'b1;
        @(negedge CLK);

        run_op("u ff*ff", 8, 1'b0, 32'hFF, 32'hFF, 64'hFE01, 0, 0, 0, 1'b0, 0, 0, -1);
        run_op("s 80*80", 8, 1'b1, 32'h80, 32'h80, 64'h4000, 0, 0, 0, 1'b0, 0, 0, -1);
        run_op("s ff*01", 8, 1'b1, 32'hFF, 32'h01, 64'hFFFF, 0, 0, 0, 1'b0, 0, 0, -1);
        run_op("u 00*a5", 8, 1'b0, 32'h00, 32'hA5, 64'h0000, 0, 0, 0, 1'b0, 0, 0, -1);
        run_op("chain 1st", 8, 1'b0, 32'h12, 32'h34, 64'h03A8, 0, 0, 1, 1'b0, 32'h03, 32'h05, -1);
        run_op("chain 2nd", 8, 1'b0, 32'h03, 32'h05, 64'h000F, 0, 1, 0, 1'b0, 0, 0, -1);
        run_op("start held", 8, 1'b0, 32'h0D, 32'h0B, 64'h008F, 1, 0, 0, 1'b0, 0, 0, -1);

        // Abort during output bit 5, then confirm silence and a clean restart.
        run_op("abort", 8, 1'b0, 32'hFF, 32'hFF, 64'h0, 0, 0, 0, 1'b0, 0, 0, 8 + 5);
        check("abort vld before rst", 64'(vld8), 64'd1);
        RST = 1'b0;
        #1;
        check("abort outputs in rst", 64'({busy8, o8, vld8, done8}), 64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        quiet = 0;
        repeat (30) begin
            @(negedge CLK);
            if (vld8 || done8 || busy8) quiet++;
        end
        check("abort stays quiet", 64'(quiet), 64'd0);
        run_op("after rst", 8, 1'b0, 32'h02, 32'h03, 64'h0006, 0, 0, 0, 1'b0, 0, 0, -1);

        run_op("w4 s 8*7", 4, 1'b1, 32'h8, 32'h7, 64'hC8, 0, 0, 0, 1'b0, 0, 0, -1);
        run_op("w4 u f*f", 4, 1'b0, 32'hF, 32'hF, 64'hE1, 0, 0, 0, 1'b0, 0, 0, -1);
        run_op("w16 s -1*-1", 16, 1'b1, 32'hFFFF, 32'hFFFF, 64'h1, 0, 0, 0, 1'b0, 0, 0, -1);

        for (int wi = 0; wi < 3; wi++) begin
            rw   = 4 << wi;
            mask = (32'd1 << rw) - 32'd1;
            for (int n = 0; n < 150; n++) begin
                ra = $urandom & mask;
                rb = $urandom & mask;
                rs = 1'($urandom);
                if (n == 0) begin ra = mask; rb = mask; end
                if (n == 1) begin ra = 32'd1 << (rw - 1); rb = ra; end
                run_op("random", rw, rs, ra, rb, ref_mul(rw, rs, ra, rb),
                       bit'($urandom_range(0, 3) == 0), 0, 0, 1'b0, 0, 0, -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
